// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: op encodings,
// FSM state type and the burst counter width helper.
package shift_reg_pkg;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_BURST = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } st_e;

  // Counter must hold the value WIDTH itself (burst length), not WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/_shift_next.sv
// Combinational next-value logic for the register and its serial output.
// Ops that do not shift (hold, load, burst start) leave so unchanged.
module _shift_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             so_i,
  input  logic [2:0]       op_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             so_next_o
);

  // Select the next register value and the bit pushed out for this op.
  always_comb begin
    q_next_o  = q_i;
    so_next_o = so_i;
    case (op_i)
      OP_LOAD: q_next_o = d_i;
      OP_SHL: begin
        q_next_o  = {q_i[WIDTH-2:0], si_i};
        so_next_o = q_i[WIDTH-1];
      end
      OP_SHR: begin
        q_next_o  = {si_i, q_i[WIDTH-1:1]};
        so_next_o = q_i[0];
      end
      OP_ROTL: begin
        q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        so_next_o = q_i[WIDTH-1];
      end
      OP_ROTR: begin
        q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
        so_next_o = q_i[0];
      end
      OP_ASR: begin
        q_next_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        so_next_o = q_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/_shift_reg_rs_param.sv
// Universal shift register with synchronous set/clear and a counted,
// pausable serial burst. The burst is a WIDTH-long run of right shifts
// reusing the same next-value logic as the single-step shr op.
module _shift_reg_rs_param
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int              CW          = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done,
  output st_e              dbg_state,
  output logic [CW-1:0]    dbg_count
);

  logic [WIDTH-1:0] q_q;
  logic             so_q;
  logic             busy_q;
  logic             done_q;
  st_e              state_q;
  logic [CW-1:0]    count_q;

  logic [2:0]       op_d;
  logic [WIDTH-1:0] q_d;
  logic             so_d;

  // While bursting the incoming op is ignored and every step is a shr.
  always_comb begin
    op_d = (state_q == ST_BURST) ? OP_SHR : op;
  end

  _shift_next #(.WIDTH(WIDTH)) u_next (
    .q_i       (q_q),
    .so_i      (so_q),
    .op_i      (op_d),
    .si_i      (si),
    .d_i       (d),
    .q_next_o  (q_d),
    .so_next_o (so_d)
  );

  // FSM, burst counter and all registered outputs; clear beats set beats op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= RESET_VALUE;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!clr_n) begin
        q_q     <= RESET_VALUE;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
        count_q <= '0;
      end else if (!set_n) begin
        q_q     <= SET_VALUE;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
        count_q <= '0;
      end else if (state_q == ST_BURST) begin
        if (en && (count_q != '0)) begin
          q_q     <= q_d;
          so_q    <= so_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
      end else if (en) begin
        if (op == OP_BURST) begin
          busy_q  <= 1'b1;
          state_q <= ST_BURST;
          count_q <= CW'(WIDTH);
        end else begin
          q_q  <= q_d;
          so_q <= so_d;
        end
      end
    end
  end

  assign q         = q_q;
  assign so        = so_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule
